pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch controller that sequences the byte-addressed, combinational-read instruction memory. It owns the 64-bit program counter and drives it to the memory. It captures the returned 32-bit instruction into a one-entry output register with a valid/ready handshake toward decode. It applies taken-branch redirects and halts when fetch runs past the end of memory.

## Interface
- `IM_BYTES`, default 256: instruction memory size in bytes; must be a multiple of 4.
- `RESET_PC`, default 0: PC value after reset; must be word-aligned.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: leave IDLE and begin fetching.
- `pc_o` out 64: fetch address to instruction memory (registered).
- `instr_i` in 32: instruction word returned combinationally for `pc_o`.
- `instr_o` out 32: buffered instruction to decode.
- `instr_pc_o` out 64: address `instr_o` was fetched from.
- `instr_valid_o` out 1: `instr_o`/`instr_pc_o` hold a valid instruction.
- `instr_ready_i` in 1: decode accepts the instruction this cycle.
- `br_valid_i` in 1: branch resolution present this cycle.
- `br_taken_i` in 1: resolved branch is taken (qualified by `br_valid_i`).
- `br_pc_i` in 64: address of the resolving branch.
- `br_offset_i` in 26: signed word offset.
- `halt_o` out 1: state is HALT.
- `fetch_count_o` out 32: count of completed decode handshakes.

## Operation
- States are IDLE, FETCH and HALT. Reset enters IDLE.
- Redirect is `br_valid_i & br_taken_i`.
  - Target = `{br_pc_i[63:2],2'b00}` + (sign-extended `br_offset_i` << 2), modulo 2^64.
  - Not-taken resolutions are ignored.
- Handshake is `instr_valid_o & instr_ready_i`. Each handshake increments `fetch_count_o`, which wraps at 2^32.
- Capture is enabled when the state is FETCH, there is no redirect, `pc_o` <= IM_BYTES-4, and (`!instr_valid_o` or handshake).
  - On capture: `instr_o` <= `instr_i`, `instr_pc_o` <= `pc_o`, `instr_valid_o` <= 1, `pc_o` <= `pc_o`+4.
- On a handshake with no capture and no redirect, `instr_valid_o` <= 0.
- When the output is full and not accepted, `pc_o`, `instr_o` and `instr_pc_o` hold.
- IDLE:
  - `start_i` moves to FETCH; no capture occurs in the same cycle.
  - A redirect in IDLE loads `pc_o` and stays in IDLE.
- FETCH:
  - If `pc_o` > IM_BYTES-4 and there is no redirect, go to HALT. No capture occurs, and `pc_o` holds.
- Redirect (from FETCH or HALT):
  - `pc_o` <= target.
  - `instr_valid_o` <= 0, flushing the buffer. A handshake in the same cycle still completes and is counted.
  - The next state is FETCH.
  - Redirect has priority over capture and halt.
- HALT:
  - `pc_o` holds.
  - The buffered instruction remains valid until it is accepted, then is cleared.
  - `start_i` is ignored; only a redirect leaves HALT.
- Simultaneous `start_i` and redirect in IDLE: PC loads the target and the state moves to FETCH.

## Timing
- Reset values:
  - `pc_o` = RESET_PC, `instr_o` = 0, `instr_pc_o` = 0.
  - `instr_valid_o` = 0, `halt_o` = 0, `fetch_count_o` = 0, state = IDLE.
- `rst_n` deassertion mid-operation discards any buffered instruction; the block does not fetch until `start_i`.
- Start to first valid: `start_i` high at edge N; the first capture is at edge N+1, so `instr_valid_o` is high after N+1.
- Throughput: one instruction per cycle while `instr_ready_i` stays high.
- Redirect latency:
  - Redirect at edge N: `pc_o` = target after N.
  - The instruction at the target is valid after N+1.
  - This gives one bubble cycle.
- `halt_o` asserts the cycle after the out-of-range PC is detected.
- Everything is registered except the capture data path from `instr_i`.

## Configuration
- `PC_SEQ_HALT_EN` defined: out-of-range fetch behaves as above (HALT).
- `PC_SEQ_HALT_EN` undefined:
  - HALT is unreachable and `halt_o` is tied to 0.
  - The PC used for fetch and capture is `pc_o` modulo IM_BYTES, so fetch wraps to address 0.
  - Redirect targets are also reduced modulo IM_BYTES.

## Test plan
- Reset and start: reset, then `start_i`=1 for one cycle, with memory word 0 = 0xF8428005 and `instr_ready_i`=1. After 1 cycle: `instr_o`=0xF8428005, `instr_pc_o`=0, `pc_o`=4; then sequential fetch of 8, 12, ….
- Backpressure: hold `instr_ready_i`=0 for 3 cycles after the first capture. `pc_o` stays 4, `instr_o` is stable, `fetch_count_o` stays 0. On release the count increments once per cycle.
- Taken branch: `br_pc_i`=24, `br_offset_i`=-2, taken, while the output is valid. Next cycle `instr_valid_o`=0 and `pc_o`=16; the following cycle `instr_pc_o`=16. Repeat with `br_taken_i`=0: there is no effect.
- Halt (`PC_SEQ_HALT_EN`): with IM_BYTES=256, fetch runs to `pc_o`=256. Then `halt_o`=1, `pc_o` holds 256, and the last word (address 252) drains. A redirect to 0 returns to FETCH with `halt_o`=0.
- Wrap (macro off): with IM_BYTES=256, after address 252 the next `instr_pc_o` is 0 and `halt_o` stays 0.
- Reset mid-stream: assert `rst_n`=0 asynchronously between edges while valid. Outputs go to reset values immediately, with `pc_o`=RESET_PC. There is no fetch until `start_i`.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: owns the PC, buffers one fetched word toward decode, applies taken-branch redirects.
// Optional macro PC_SEQ_HALT_EN: halt on out-of-range fetch; when undefined the fetch address wraps modulo IM_BYTES.
module pc_sequencer #(
   parameter int          IM_BYTES = 256,
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   output logic [63:0] pc_o,
   input  logic [31:0] instr_i,
   output logic [31:0] instr_o,
   output logic [63:0] instr_pc_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   input  logic        br_valid_i,
   input  logic        br_taken_i,
   input  logic [63:0] br_pc_i,
   input  logic [25:0] br_offset_i,
   output logic        halt_o,
   output logic [31:0] fetch_count_o
);

   localparam logic [63:0] IM_SIZE   = 64'(IM_BYTES);
   localparam logic [63:0] LAST_WORD = IM_SIZE - 64'd4;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

   state_t      r_state, w_state_nxt;
   logic [63:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr;
   logic [63:0] r_instr_pc;
   logic        r_valid, w_valid_nxt;
   logic [31:0] r_count;

   logic        w_redirect, w_hs, w_capture, w_in_range;
   logic [63:0] w_target_raw, w_target, w_fetch_pc, w_pc_inc;

   assign w_redirect   = br_valid_i & br_taken_i;
   assign w_hs         = r_valid & instr_ready_i;
   assign w_target_raw = (br_pc_i & ~64'd3) + {{36{br_offset_i[25]}}, br_offset_i, 2'b00};

`ifdef PC_SEQ_HALT_EN
   assign w_fetch_pc = r_pc;
   assign w_in_range = (r_pc <= LAST_WORD);
   assign w_target   = w_target_raw;
   assign w_pc_inc   = r_pc + 64'd4;
   assign halt_o     = (r_state == S_HALT);
`else
   // PC is kept reduced so the address driven to memory is always in range.
   assign w_fetch_pc = r_pc % IM_SIZE;
   assign w_in_range = 1'b1;
   assign w_target   = w_target_raw % IM_SIZE;
   assign w_pc_inc   = (w_fetch_pc == LAST_WORD) ? 64'd0 : w_fetch_pc + 64'd4;
   assign halt_o     = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_valid_nxt = r_valid & ~w_hs;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_redirect) w_pc_nxt = w_target;
            if (start_i) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (w_redirect) begin
               w_pc_nxt    = w_target;
               w_valid_nxt = 1'b0;
            end else if (!w_in_range) begin
               w_state_nxt = S_HALT;
            end else if (!r_valid || w_hs) begin
               w_capture   = 1'b1;
               w_pc_nxt    = w_pc_inc;
               w_valid_nxt = 1'b1;
            end
         end
         S_HALT: begin
            if (w_redirect) begin
               w_pc_nxt    = w_target;
               w_valid_nxt = 1'b0;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_instr    <= 32'd0;
         r_instr_pc <= 64'd0;
         r_valid    <= 1'b0;
         r_count    <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_valid <= w_valid_nxt;
         if (w_capture) begin
            r_instr    <= instr_i;
            r_instr_pc <= w_fetch_pc;
         end
         if (w_hs) r_count <= r_count + 32'd1;
      end
   end

   assign pc_o          = r_pc;
   assign instr_o       = r_instr;
   assign instr_pc_o    = r_instr_pc;
   assign instr_valid_o = r_valid;
   assign fetch_count_o = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan checks plus randomized traffic against a cycle-level behavioural model.
module tb_pc_sequencer;
   localparam int          IM  = 256;
   localparam int          AW  = $clog2(IM);
   localparam logic [63:0] RPC = 64'd0;
`ifdef PC_SEQ_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [63:0] pc_o;
   logic [31:0] instr_i;
   logic [31:0] instr_o;
   logic [63:0] instr_pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic        br_valid_i = 1'b0;
   logic        br_taken_i = 1'b0;
   logic [63:0] br_pc_i = 64'd0;
   logic [25:0] br_offset_i = 26'd0;
   logic        halt_o;
   logic [31:0] fetch_count_o;

   int n_pass = 0;
   int n_total = 0;

   logic [31:0] mem [IM/4];

   pc_sequencer #(.IM_BYTES(IM), .RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .pc_o(pc_o), .instr_i(instr_i),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i), .br_valid_i(br_valid_i), .br_taken_i(br_taken_i),
      .br_pc_i(br_pc_i), .br_offset_i(br_offset_i), .halt_o(halt_o), .fetch_count_o(fetch_count_o)
   );

   always #5 clk = ~clk;

   assign instr_i = (pc_o < 64'(IM)) ? mem[pc_o[AW-1:2]] : 32'hDEADBEEF;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
   endtask

   // Behavioural model: 0=idle, 1=fetching, 2=halted
   int          m_st;
   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_instr, m_cnt;
   logic        m_valid;

   task automatic model_reset();
      m_st = 0; m_pc = RPC; m_ipc = 64'd0; m_instr = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
   endtask

   task automatic model_step();
      logic               redir, hs, inr;
      logic signed [63:0] soff;
      logic [63:0]        tgt, fa;
      redir = br_valid_i && br_taken_i;
      soff  = 64'($signed(br_offset_i));
      tgt   = (br_pc_i & ~64'd3) + 64'(soff * 4);
      if (!HALT_EN) tgt = tgt % 64'(IM);
      fa    = HALT_EN ? m_pc : m_pc % 64'(IM);
      inr   = (fa <= 64'(IM - 4));
      hs    = m_valid && instr_ready_i;
      if (hs) m_cnt = m_cnt + 32'd1;
      if (m_st == 0) begin
         if (redir) m_pc = tgt;
         if (start_i) m_st = 1;
      end else if (redir) begin
         m_pc = tgt; m_valid = 1'b0; m_st = 1;
      end else if (m_st == 2 || !inr) begin
         m_st = 2;
         if (hs) m_valid = 1'b0;
      end else if (!m_valid || hs) begin
         m_instr = mem[int'(fa >> 2)];
         m_ipc   = fa;
         m_pc    = HALT_EN ? fa + 64'd4 : (fa + 64'd4) % 64'(IM);
         m_valid = 1'b1;
      end
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (rst_n) model_step();
      #1;
      chk("pc_o", pc_o, m_pc);
      chk("instr_valid_o", 64'(instr_valid_o), 64'(m_valid));
      chk("instr_o", 64'(instr_o), 64'(m_instr));
      chk("instr_pc_o", instr_pc_o, m_ipc);
      chk("fetch_count_o", 64'(fetch_count_o), 64'(m_cnt));
      chk("halt_o", 64'(halt_o), 64'(m_st == 2));
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic branch(input logic [63:0] bpc, input logic [25:0] off, input logic tk);
      br_valid_i = 1'b1; br_taken_i = tk; br_pc_i = bpc; br_offset_i = off;
      step(1);
      br_valid_i = 1'b0; br_taken_i = 1'b0;
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < IM/4; i++) mem[i] = $urandom;
      mem[0] = 32'hF8428005;
      #3;
      chk("reset pc", pc_o, RPC);
      chk("reset valid", 64'(instr_valid_o), 64'd0);
      chk("reset count", 64'(fetch_count_o), 64'd0);
      chk("reset halt", 64'(halt_o), 64'd0);
      chk("reset instr", 64'(instr_o), 64'd0);
      step(1);
      rst_n = 1'b1;

      // start, first capture one edge later
      start_i = 1'b1; instr_ready_i = 1'b1;
      step(1);
      start_i = 1'b0;
      chk("start no capture", 64'(instr_valid_o), 64'd0);
      step(1);
      chk("first instr", 64'(instr_o), 64'hF8428005);
      chk("first ipc", instr_pc_o, 64'd0);
      chk("first pc", pc_o, 64'd4);
      chk("first valid", 64'(instr_valid_o), 64'd1);

      // backpressure
      instr_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("bp pc hold", pc_o, 64'd4);
         chk("bp instr hold", 64'(instr_o), 64'hF8428005);
         chk("bp count hold", 64'(fetch_count_o), 64'd0);
      end
      instr_ready_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step(1);
         chk("release count", 64'(fetch_count_o), 64'(k));
         chk("release pc", pc_o, 64'(4 + 4*k));
      end

      // taken branch: 24 + (-2*4) = 16
      branch(64'd24, 26'h3FFFFFE, 1'b1);
      chk("br flush", 64'(instr_valid_o), 64'd0);
      chk("br pc", pc_o, 64'd16);
      chk("br hs counted", 64'(fetch_count_o), 64'd4);
      step(1);
      chk("br target ipc", instr_pc_o, 64'd16);
      chk("br target valid", 64'(instr_valid_o), 64'd1);
      branch(64'd24, 26'h3FFFFFE, 1'b0);
      chk("not-taken pc", pc_o, 64'd24);
      chk("not-taken ipc", instr_pc_o, 64'd20);

      // end of memory
      branch(64'd240, 26'd0, 1'b1);
      chk("redir 240", pc_o, 64'd240);
      step(5);
      if (HALT_EN) begin
         chk("halt asserted", 64'(halt_o), 64'd1);
         chk("halt pc", pc_o, 64'd256);
         chk("halt drained", 64'(instr_valid_o), 64'd0);
         chk("halt last ipc", instr_pc_o, 64'd252);
         start_i = 1'b1;
         step(1);
         start_i = 1'b0;
         chk("halt holds", 64'(halt_o), 64'd1);
         chk("halt pc holds", pc_o, 64'd256);
      end else begin
         chk("wrap ipc", instr_pc_o, 64'd0);
         chk("wrap no halt", 64'(halt_o), 64'd0);
         chk("wrap valid", 64'(instr_valid_o), 64'd1);
         chk("wrap pc", pc_o, 64'd4);
      end
      branch(64'd0, 26'd0, 1'b1);
      chk("redir0 halt", 64'(halt_o), 64'd0);
      chk("redir0 pc", pc_o, 64'd0);
      step(2);

      // asynchronous reset between edges
      chk("pre-reset valid", 64'(instr_valid_o), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async pc", pc_o, RPC);
      chk("async valid", 64'(instr_valid_o), 64'd0);
      chk("async instr", 64'(instr_o), 64'd0);
      chk("async ipc", instr_pc_o, 64'd0);
      chk("async count", 64'(fetch_count_o), 64'd0);
      #3;
      rst_n = 1'b1;
      step(3);
      chk("idle no fetch valid", 64'(instr_valid_o), 64'd0);
      chk("idle no fetch pc", pc_o, RPC);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0; #2; rst_n = 1'b1;
         end
         start_i       = ($urandom_range(0, 3) == 0);
         instr_ready_i = ($urandom_range(0, 3) != 0);
         br_valid_i    = ($urandom_range(0, 9) == 0);
         br_taken_i    = 1'($urandom_range(0, 1));
         br_pc_i       = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                                     : 64'($urandom_range(0, IM + 32));
         br_offset_i   = ($urandom_range(0, 5) == 0) ? 26'($urandom)
                                                     : 26'($urandom_range(0, 40)) - 26'd20;
         step(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
